// File: rtl/ft_tx_arbiter.sv
// Round-robin omux consumer that writes granted bytes into the FT2232 TX FIFO with an FT245 WR
// strobe. A granted source keeps the grant while its request stays high, so records stay atomic.
module ft_tx_arbiter #(
  parameter int unsigned SRC_COUNT    = 2,
  parameter int unsigned WR_CYCLES    = 3,
  parameter int unsigned RECOV_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_ni,
  input  logic                   ntxe_i,
  output logic                   wr_o,
  output logic [7:0]             d_o,
  output logic                   d_oe_o,
  input  logic                   rd_pending_i,
  output logic                   tx_busy_o,
  input  logic [SRC_COUNT-1:0]   omux_req_i,
  input  logic [8*SRC_COUNT-1:0] omux_data_i,
  output logic [SRC_COUNT-1:0]   omux_sel_o,
  output logic [31:0]            byte_count_o
);

  localparam int unsigned PtrW   = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
  localparam int unsigned CntMax = (WR_CYCLES > RECOV_CYCLES) ? WR_CYCLES : RECOV_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {StIdle, StSetup, StStrobe, StHold, StRecov} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] grant_q, grant_d;
  logic            lock_q, lock_d;
  logic [7:0]      d_q, d_d;
  logic [31:0]     byte_count_q, byte_count_d;
  logic            txe_meta_q, txe_s_q;

  logic            rr_found;
  logic [PtrW-1:0] rr_idx;
  logic [PtrW-1:0] grant_next;

  // TXE# is asynchronous; synchronizer resets to "FIFO full" so nothing is written early.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      txe_meta_q <= 1'b1;
      txe_s_q    <= 1'b1;
    end else begin
      txe_meta_q <= ntxe_i;
      txe_s_q    <= txe_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ptr_q        <= '0;
      grant_q      <= '0;
      lock_q       <= 1'b0;
      d_q          <= 8'h00;
      byte_count_q <= 32'h0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      grant_q      <= grant_d;
      lock_q       <= lock_d;
      d_q          <= d_d;
      byte_count_q <= byte_count_d;
    end
  end

  // First requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned cand;
    logic [PtrW-1:0] cand_idx;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int unsigned i = 0; i < SRC_COUNT; i++) begin
      cand = 32'(ptr_q) + i;
      if (cand >= SRC_COUNT) cand = cand - SRC_COUNT;
      cand_idx = PtrW'(cand);
      if (!rr_found && omux_req_i[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  assign grant_next = (32'(grant_q) == SRC_COUNT - 1) ? '0 : grant_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    grant_d      = grant_q;
    lock_d       = lock_q;
    d_d          = d_q;
    byte_count_d = byte_count_q;
    unique case (state_q)
      StIdle: begin
        if (lock_q) begin
          if (omux_req_i[grant_q]) begin
            if (!txe_s_q) begin
              d_d     = omux_data_i[32'(grant_q)*8 +: 8];
              state_d = StSetup;
            end
          end else begin
            lock_d = 1'b0;
            ptr_d  = grant_next;
          end
        end else if (!rd_pending_i && !txe_s_q && rr_found) begin
          grant_d = rr_idx;
          lock_d  = 1'b1;
          d_d     = omux_data_i[32'(rr_idx)*8 +: 8];
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = CntW'(WR_CYCLES - 1);
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == '0) state_d = StHold;
        else             cnt_d   = cnt_q - 1'b1;
      end
      StHold: begin
        byte_count_d = byte_count_q + 32'd1;
        cnt_d        = CntW'(RECOV_CYCLES - 1);
        state_d      = StRecov;
      end
      StRecov: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode from state only, so an asynchronous reset clears them at once.
  always_comb begin
    wr_o       = 1'b0;
    d_oe_o     = 1'b0;
    omux_sel_o = '0;
    unique case (state_q)
      StSetup:  d_oe_o = 1'b1;
      StStrobe: begin
        wr_o   = 1'b1;
        d_oe_o = 1'b1;
      end
      StHold: begin
        d_oe_o              = 1'b1;
        omux_sel_o[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign d_o          = d_q;
  assign byte_count_o = byte_count_q;
  assign tx_busy_o    = d_oe_o | lock_q;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter: queue-driven omux sources, negedge monitors, and
// hand-computed expectations checked with immediate assertions.
module tb_ft_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        ntxe_i;
  logic        wr_o;
  logic [7:0]  d_o;
  logic        d_oe_o;
  logic        rd_pending_i;
  logic        tx_busy_o;
  logic [1:0]  omux_req_i = 2'b00;
  logic [15:0] omux_data_i = 16'h0;
  logic [1:0]  omux_sel_o;
  logic [31:0] byte_count_o;

  ft_tx_arbiter #(
    .SRC_COUNT   (2),
    .WR_CYCLES   (3),
    .RECOV_CYCLES(4)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_ni),
    .ntxe_i      (ntxe_i),
    .wr_o        (wr_o),
    .d_o         (d_o),
    .d_oe_o      (d_oe_o),
    .rd_pending_i(rd_pending_i),
    .tx_busy_o   (tx_busy_o),
    .omux_req_i  (omux_req_i),
    .omux_data_i (omux_data_i),
    .omux_sel_o  (omux_sel_o),
    .byte_count_o(byte_count_o)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source queues hold {last, byte}; after a record's last byte the source keeps req low
  // for six negedges, i.e. exactly through the arbiter's release cycle.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  int gap0 = 0;
  int gap1 = 0;

  always @(negedge clk) begin
    if (gap0 > 0) gap0--;
    if (gap1 > 0) gap1--;
    if (omux_sel_o[0] && q0.size() > 0) begin
      if (q0[0][8]) gap0 = 6;
      q0.delete(0);
    end
    if (omux_sel_o[1] && q1.size() > 0) begin
      if (q1[0][8]) gap1 = 6;
      q1.delete(0);
    end
    omux_req_i[0]     = (q0.size() > 0) && (gap0 == 0);
    omux_req_i[1]     = (q1.size() > 0) && (gap1 == 0);
    omux_data_i[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    omux_data_i[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
  end

  int          log_src[$];
  logic [7:0]  log_dat[$];
  int          wr_w_q[$];
  int unsigned wr_rise_q[$];
  int          cur_w = 0;
  logic        wr_prev = 1'b0;
  int          multi_sel = 0;
  int          oe_seen = 0;

  always @(negedge clk) begin
    if (wr_o && !wr_prev) wr_rise_q.push_back(cyc);
    if (wr_o) cur_w++;
    else if (cur_w > 0) begin
      wr_w_q.push_back(cur_w);
      cur_w = 0;
    end
    wr_prev = wr_o;
    if ($countones(omux_sel_o) > 1) multi_sel++;
    if (omux_sel_o != 2'b00) begin
      log_src.push_back(omux_sel_o[1] ? 1 : 0);
      log_dat.push_back(d_o);
    end
    if (d_oe_o) oe_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_log(input int n, input int bound, input string tag);
    for (int i = 0; i < bound; i++) begin
      tick(1);
      if (log_dat.size() >= n) break;
    end
    chk({tag, "_done"}, 32'(log_dat.size() >= n), 32'd1);
  endtask

  task automatic chk_log(input int idx, input int src, input logic [7:0] dat, input string tag);
    chk({tag, "_src"}, 32'(log_src[idx]), 32'(src));
    chk({tag, "_dat"}, 32'(log_dat[idx]), 32'(dat));
  endtask

  initial begin
    int base;
    int k;
    reset_ni     = 1'b0;
    ntxe_i       = 1'b1;
    rd_pending_i = 1'b0;
    tick(3);
    chk("rst_wr", 32'(wr_o), 32'd0);
    chk("rst_doe", 32'(d_oe_o), 32'd0);
    chk("rst_d", 32'(d_o), 32'd0);
    chk("rst_sel", 32'(omux_sel_o), 32'd0);
    chk("rst_busy", 32'(tx_busy_o), 32'd0);
    chk("rst_count", byte_count_o, 32'd0);
    reset_ni = 1'b1;

    // Single record from source 0.
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b0, 8'hB2});
    q0.push_back({1'b1, 8'hC3});
    ntxe_i = 1'b0;
    wait_log(3, 100, "single");
    chk_log(0, 0, 8'hA1, "single0");
    chk_log(1, 0, 8'hB2, "single1");
    chk_log(2, 0, 8'hC3, "single2");
    chk("single_npulses", 32'(wr_w_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("single_width", 32'(wr_w_q[i]), 32'd3);
    chk("single_period01", wr_rise_q[1] - wr_rise_q[0], 32'd10);
    chk("single_period12", wr_rise_q[2] - wr_rise_q[1], 32'd10);
    chk("single_count", byte_count_o, 32'd3);

    // Pointer now at 1: one byte from source 1 moves it back to 0.
    tick(10);
    q1.push_back({1'b1, 8'h11});
    wait_log(4, 100, "rr_pre");
    chk_log(3, 1, 8'h11, "rr_pre");
    tick(10);

    // Source 0 two-byte record, then contests against source 1: source 1 must win.
    q0.push_back({1'b0, 8'h21});
    q0.push_back({1'b1, 8'h22});
    q0.push_back({1'b1, 8'h23});
    q1.push_back({1'b1, 8'h31});
    wait_log(8, 200, "rr");
    chk_log(4, 0, 8'h21, "rr0");
    chk_log(5, 0, 8'h22, "rr1");
    chk_log(6, 1, 8'h31, "rr2");
    chk_log(7, 0, 8'h23, "rr3");
    tick(10);

    // Backpressure.
    ntxe_i = 1'b1;
    tick(5);
    base = log_dat.size();
    k = wr_rise_q.size();
    q0.push_back({1'b1, 8'h71});
    tick(20);
    chk("bp_no_sel", 32'(log_dat.size()), 32'(base));
    chk("bp_no_wr", 32'(wr_rise_q.size()), 32'(k));
    ntxe_i = 1'b0;
    k = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      k++;
      if (wr_o) break;
    end
    chk("bp_latency_4to5", 32'(k >= 4 && k <= 5), 32'd1);
    wait_log(base + 1, 50, "bp");
    chk_log(base, 0, 8'h71, "bp");
    tick(10);

    // Read yield while idle.
    rd_pending_i = 1'b1;
    base = log_dat.size();
    k = oe_seen;
    q0.push_back({1'b1, 8'h81});
    tick(30);
    chk("rd_idle_no_sel", 32'(log_dat.size()), 32'(base));
    chk("rd_idle_doe", 32'(d_oe_o), 32'd0);
    chk("rd_idle_oe_never", 32'(oe_seen), 32'(k));
    chk("rd_idle_busy", 32'(tx_busy_o), 32'd0);
    rd_pending_i = 1'b0;
    wait_log(base + 1, 50, "rd_release");
    chk_log(base, 0, 8'h81, "rd_release");
    tick(10);

    // Read request mid-record: record completes, then the block yields.
    base = log_dat.size();
    q0.push_back({1'b0, 8'h91});
    q0.push_back({1'b1, 8'h92});
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (d_oe_o) break;
    end
    chk("rd_mid_started", 32'(d_oe_o), 32'd1);
    rd_pending_i = 1'b1;
    wait_log(base + 2, 60, "rd_mid");
    chk_log(base, 0, 8'h91, "rd_mid0");
    chk_log(base + 1, 0, 8'h92, "rd_mid1");
    q1.push_back({1'b1, 8'hA5});
    tick(30);
    chk("rd_mid_yield", 32'(log_dat.size()), 32'(base + 2));
    rd_pending_i = 1'b0;
    wait_log(base + 3, 50, "rd_after");
    chk_log(base + 2, 1, 8'hA5, "rd_after");
    tick(10);

    // Put the pointer on source 1, then reset while its byte is strobing.
    base = log_dat.size();
    q0.push_back({1'b1, 8'hB7});
    wait_log(base + 1, 50, "pre_rst");
    chk_log(base, 0, 8'hB7, "pre_rst");
    tick(10);
    q0.push_back({1'b1, 8'hC1});
    q1.push_back({1'b1, 8'hD1});
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (wr_o) break;
    end
    chk("rst_mid_strobing", 32'(wr_o), 32'd1);
    chk("rst_mid_grant_d", 32'(d_o), 32'hD1);
    #2;
    reset_ni = 1'b0;
    #1;
    chk("rst_mid_wr", 32'(wr_o), 32'd0);
    chk("rst_mid_doe", 32'(d_oe_o), 32'd0);
    chk("rst_mid_count", byte_count_o, 32'd0);
    chk("rst_mid_sel", 32'(omux_sel_o), 32'd0);
    chk("rst_mid_busy", 32'(tx_busy_o), 32'd0);
    tick(2);
    reset_ni = 1'b1;
    base = log_dat.size();
    wait_log(base + 2, 100, "post_rst");
    chk_log(base, 0, 8'hC1, "post_rst0");
    chk_log(base + 1, 1, 8'hD1, "post_rst1");
    chk("post_rst_count", byte_count_o, 32'd2);
    tick(10);

    // Counter wrap.
    @(negedge clk);
    force dut.byte_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.byte_count_q;
    tick(1);
    chk("wrap_preset", byte_count_o, 32'hFFFF_FFFF);
    base = log_dat.size();
    q0.push_back({1'b1, 8'hE1});
    wait_log(base + 1, 50, "wrap");
    chk_log(base, 0, 8'hE1, "wrap");
    chk("wrap_count", byte_count_o, 32'd0);

    chk("single_sel_onehot", 32'(multi_sel), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ft_tx_arbiter.md
# ft_tx_arbiter

Transmit-side companion to the record buffer. It arbitrates between omux byte sources (record buffer, register read-back, future status streams) and writes the granted bytes into the FT2232 transmit FIFO using the asynchronous FT245-style WR strobe. It is the consumer end of the omux protocol: sources raise `omux_req`, present a byte, and advance when this block pulses their `omux_sel`. It shares the FT2232 data bus with the host receive path and yields the bus between records when a read is pending.

## Interface
- `SRC_COUNT`, 2: number of omux sources; index 0 has the highest initial priority.
- `WR_CYCLES`, 3: clk cycles for which `wr_o` is held high per byte.
- `RECOV_CYCLES`, 4: idle cycles after each byte before `ntxe` is re-sampled.

- `clk_i`  in  1  system clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `ntxe_i`  in  1  FT2232 TXE#, asynchronous; low means FIFO space is available.
- `wr_o`  out  1  FT2232 WR strobe; data is latched on the falling edge.
- `d_o`  out  8  transmit byte; routed to the `d_io` tristate.
- `d_oe_o`  out  1  drive enable for `d_io`.
- `rd_pending_i`  in  1  the receive path requests the bus.
- `tx_busy_o`  out  1  high while this block owns the bus (`d_oe_o`) or holds a record lock.
- `omux_req_i`  in  SRC_COUNT  per-source request; held high while a byte is offered.
- `omux_data_i`  in  8*SRC_COUNT  per-source byte, source k at [8k+7:8k].
- `omux_sel_o`  out  SRC_COUNT  one-cycle consume strobe; the source presents its next byte on the following cycle.
- `byte_count_o`  out  32  total bytes written; wraps modulo 2^32.

## Operation
- `ntxe_i` passes through a 2-flop synchronizer to form `txe_s`. Only `txe_s` is used internally.
- **Lock.** A granted source keeps the grant while its `omux_req` stays high. This makes a multi-byte record atomic; sources drop `req` only at record end.
- **IDLE/ARB.** Each cycle the block evaluates in this order:
  - If a source is locked, `omux_req[g]` is high, and `txe_s`=0: capture `omux_data[g]` into `d_o` and go to SETUP.
  - If the locked source's `req` is low: release the lock and advance the pointer to g+1 mod SRC_COUNT.
  - If unlocked, `rd_pending_i`=0, and `txe_s`=0: grant the first requester found round-robin from the pointer, capture its byte, and go to SETUP.
  - If unlocked and `rd_pending_i`=1: the block stays idle with `d_oe_o`=0.
- **SETUP.** 1 cycle. `d_oe_o`=1, `wr_o`=0.
- **STROBE.** WR_CYCLES cycles. `wr_o`=1, `d_oe_o`=1.
- **HOLD.** 1 cycle. `wr_o`=0, data and `d_oe_o` are still driven. `omux_sel[g]` pulses and `byte_count_o` increments.
- **RECOV.** RECOV_CYCLES cycles. `d_oe_o`=0, then return to ARB.
- At most one `omux_sel` bit is high in any cycle.
- `rd_pending_i` never interrupts a byte or a locked record.
- If a source drops `req` after capture (protocol violation), the captured byte is still written and `sel` is still pulsed.

## Timing
- Reset values: `wr_o`=0, `d_oe_o`=0, `d_o`=0, `omux_sel_o`=0, `tx_busy_o`=0, `byte_count_o`=0. Pointer=0, no lock, synchronizer flops=1, state IDLE.
- Assertion of `reset_ni` mid-byte forces all outputs to their reset values immediately. The partial byte is not counted and no `sel` is issued.
- Byte period with `txe_s` steady low: 1 (ARB) + 1 + WR_CYCLES + 1 + RECOV_CYCLES = 10 cycles at the defaults.
- Latency from `ntxe_i` falling to the ARB decision is 2–3 cycles.
- An `ntxe_i` rise during STROBE/HOLD/RECOV has no effect on the current byte. It is honoured at the next ARB.
- `d_o` is stable from SETUP through HOLD, which gives ≥1 cycle of setup and ≥1 cycle of hold around the WR falling edge.
- `byte_count_o` updates on the clock edge that ends HOLD.

## Test plan
- **Single record.** Source 0 offers 0xA1, 0xB2, 0xC3, then drops `req`; `ntxe_i`=0.
  - Three WR pulses, each 3 cycles high, 10 cycles apart.
  - Bytes latched in order A1, B2, C3.
  - Three `sel[0]` pulses; `byte_count_o`=3.
- **Round robin with lock.** Both sources request; source 0 sends a 2-byte record, source 1 a 1-byte record.
  - Output order: s0, s0, s1.
  - After the next `req` from both, source 1 is granted first.
- **Backpressure.** Hold `ntxe_i`=1 with source 0 requesting.
  - `wr_o` stays 0 and no `sel` is issued.
  - Release `ntxe_i`: the first WR rise occurs 4–5 cycles later.
- **Read yield.** Set `rd_pending_i`=1 while idle with a requester present.
  - No transfer occurs and `d_oe_o`=0.
  - Raise `rd_pending_i` mid-record: the record completes before the block yields.
- **Reset mid-byte.** Assert `reset_ni` during STROBE.
  - `wr_o` and `d_oe_o` drop asynchronously and `byte_count_o`=0.
  - The first byte after reset comes from source 0.
- **Counter wrap.** Force `byte_count_o`=0xFFFFFFFF, then send 1 byte → `byte_count_o`=0.
